// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the M-extension op/state encodings.
package rv32_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/mdu_datapath.sv
// Shift-add multiplier / restoring divider sharing one hi:lo register pair.
// Multiply: lo holds the multiplier, d_q the multiplicand. Divide: lo holds the dividend, d_q the divisor.
module mdu_datapath
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  mdu_op_e         op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] res
);
  mdu_op_e         op_q;
  logic [XLEN-1:0] hi, lo, d_q;
  logic            neg_p_q, neg_r_q;
  logic            sa, sb, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   add_sum, shl_rem, sub_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op)
      MDU_MULH, MDU_DIV, MDU_REM: begin sa = op_a[XLEN-1]; sb = op_b[XLEN-1]; end
      MDU_MULHSU:                 sa = op_a[XLEN-1];
      default: ;
    endcase
    a_mag  = sa ? -op_a : op_a;
    b_mag  = sb ? -op_b : op_b;
    is_div = op[2];
  end

  always_comb begin
    add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, d_q} : '0);
    shl_rem  = {hi, lo[XLEN-1]};
    sub_diff = shl_rem - {1'b0, d_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MDU_MUL;
      hi      <= '0;
      lo      <= '0;
      d_q     <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (load) begin
      op_q    <= op;
      hi      <= '0;
      lo      <= is_div ? a_mag : b_mag;
      d_q     <= is_div ? b_mag : a_mag;
      neg_p_q <= sa ^ sb;
      neg_r_q <= sa;
    end else if (step) begin
      if (op_q[2]) begin
        // Restore by keeping the shifted remainder when the trial subtract borrows.
        hi <= sub_diff[XLEN] ? shl_rem[XLEN-1:0] : sub_diff[XLEN-1:0];
        lo <= {lo[XLEN-2:0], ~sub_diff[XLEN]};
      end else begin
        hi <= add_sum[XLEN:1];
        lo <= {add_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = neg_p_q ? -{hi, lo} : {hi, lo};
    quo  = neg_p_q ? -lo : lo;
    rem  = neg_r_q ? -hi : hi;
    case (op_q)
      MDU_MUL:                       res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:             res = quo;
      default:                       res = rem;
    endcase
  end
endmodule

// File: rtl/mdu_ex_sequencer.sv
// EX-stage RV32M sequencer: FSM, iteration counter, special-case detect and result hold.
module mdu_ex_sequencer
  import rv32_pkg::*;
#(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  mdu_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            b_zero, ovf, special_d, spec_q;
  logic [XLEN-1:0] spec_val_d, spec_val_q, dp_res, result_q, final_res;

  assign accept = (state == IDLE) & req_i & ~flush_i;

  // Division corner cases have architecturally defined results; they override the datapath.
  always_comb begin
    b_zero     = (op_b_i == '0);
    ovf        = ((func3_i == MDU_DIV) || (func3_i == MDU_REM)) &&
                 (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    special_d  = func3_i[2] & (b_zero | ovf);
    spec_val_d = b_zero ? (func3_i[1] ? op_a_i : '1) : (func3_i[1] ? '0 : op_a_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (EARLY_OUT && special_d) ? DONE : CALC;
      CALC: if (cnt == CW'(XLEN-1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    busy_o   = (state != IDLE);
    done_o   = (state == DONE) & ~flush_i;
    stall_o  = req_i & ~done_o & ~flush_i;
    final_res = spec_q ? spec_val_q : dp_res;
    result_o = done_o ? final_res : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        cnt        <= '0;
        spec_q     <= special_d;
        spec_val_q <= spec_val_d;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
      if (done_o) result_q <= final_res;
    end
  end

  mdu_datapath #(.XLEN(XLEN)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (state == CALC),
    .op    (mdu_op_e'(func3_i)),
    .op_a  (op_a_i),
    .op_b  (op_b_i),
    .res   (dp_res)
  );
endmodule
